vec_divmod_unit: RTL
====================

Name: vec_divmod_unit

Overview:
- Multi-cycle responder for the vector VDIV/VMOD instructions. The combinational ALU cannot complete these in one cycle, so the issue stage hands them to this block.
- Accepts a start request with rA/rB operands, R_ins and WW, and runs a lane-parallel unsigned restoring division.
- Returns quotient (VDIV) or remainder (VMOD) with a done pulse.
- Bit numbering is big-endian throughout ([0:63]; bit 0 = MSB); lane 0 is the most significant lane.

Parameters:
- DATA_W, 64, operand/result width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold 64.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe from the issue stage.
- rA_64bit_val  input  [0:63]  dividend vector.
- rB_64bit_val  input  [0:63]  divisor vector.
- R_ins  input  [0:5]  function code: 6'b001110 = VDIV, 6'b001111 = VMOD.
- WW  input  [0:1]  lane width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = 64b.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- div_out  output  [0:63]  result vector.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, div_out=0. Internal quotient, remainder, counter and captured controls are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 with R_ins in {VDIV, VMOD} is an accept.
  - On accept, latch rA, rB, R_ins and WW.
  - Set the counter to the lane width W (8/16/32/64), clear the partial remainders, and enter RUN.
  - busy rises the cycle after the accept edge.
- IDLE: start=1 with any other R_ins is ignored. No busy, no done.
- start while busy=1 is ignored. Inputs are not re-sampled until IDLE.
- RUN: one quotient bit per lane per cycle.
  - Each lane of width W shifts {rem, dividend} left by one.
  - If rem >= divisor, it subtracts and sets the quotient bit.
  - Lanes are independent: no carry or borrow crosses a lane boundary.
  - The counter decrements; when it reaches 1, go to DONE.
- DONE (exactly one cycle): done=1, busy=0, then back to IDLE.
  - div_out = quotient for VDIV, remainder for VMOD.
  - div_out updates on the edge entering DONE and holds until the next accepted op completes or reset.
- Latency: accept at edge k, done high in the cycle after edge k+W+1. That is 9 / 17 / 33 / 65 edges for WW = 00 / 01 / 10 / 11.
- A new start is accepted in the DONE cycle's following IDLE cycle at the earliest. There is no accept during DONE.
- Divide by zero, per lane: quotient = all ones in that lane; remainder = that lane's dividend. Other lanes are unaffected.
- Results are unsigned only; there is no overflow case.
- Reset asserted mid-RUN aborts the op; no done is produced.

Decomposition:
- Shared package (alu_pkg) holds:
  - WW encodings: WW_8, WW_16, WW_32, WW_64.
  - R_ins codes: VDIV = 6'b001110, VMOD = 6'b001111.
  - Lane-mask constants per WW, used to cut shift/subtract carries at lane boundaries.
  - State encoding.
- Sub-module: divmod_step. It is combinational.
  - Inputs: 64-bit remainder, dividend and divisor, plus WW.
  - Outputs: the next remainder, the next dividend and the quotient-bit vector for one iteration, all lanes in parallel.
  - The top level instantiates it once and owns the FSM and registers.

Test Plan:
- VMOD, WW=11, rA=64'd102, rB=64'd10 -> div_out=64'd2. done arrives exactly 65 edges after the accept; busy is high for 64 cycles.
- VDIV, WW=00, rA=64'hFF00FF00_FF00FF00, rB=64'h11221122_44444444 -> div_out=64'h0F000F00_03000300. done arrives 9 edges after the accept.
- Divide by zero, WW=10, rA=64'h00000007_00000009, rB=64'h00000000_00000002:
  - VDIV -> 64'hFFFFFFFF_00000004.
  - VMOD -> 64'h00000007_00000001.
- Lane isolation, WW=01, rA=64'h0001_FFFF_8000_0064, rB=64'h0002_0001_0100_000A, VDIV -> 64'h0000_FFFF_0080_000A. No cross-lane borrow.
- Handshake and rejects:
  - start with R_ins=6'b000110 produces no busy and no done.
  - A second start pulse mid-RUN is ignored; div_out reflects the first op only.
- Reset mid-RUN (WW=11, 20 cycles in): busy=0, done=0 and div_out=0 immediately. A following op then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the vector divide/modulo unit: lane-width codes,
// function codes, per-width lane masks and the controller state type.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // Lane-width encodings carried on WW
  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  // Function codes handled by this unit
  localparam logic [5:0] VDIV = 6'b001110;
  localparam logic [5:0] VMOD = 6'b001111;

  // Marks the least significant bit of every lane. Bits are big-endian
  // numbered, so these are ordinary numeric constants: the lane LSB is the
  // numerically lowest bit of each lane. Clearing these bits after a left
  // shift stops a neighbouring lane's MSB from leaking into this lane.
  localparam logic [0:63] LSB_MASK_8  = 64'h0101_0101_0101_0101;
  localparam logic [0:63] LSB_MASK_16 = 64'h0001_0001_0001_0001;
  localparam logic [0:63] LSB_MASK_32 = 64'h0000_0001_0000_0001;
  localparam logic [0:63] LSB_MASK_64 = 64'h0000_0000_0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Select the lane-LSB mask for a width code
  function automatic logic [0:63] lane_lsb_mask(input logic [1:0] ww);
    case (ww)
      WW_8:    lane_lsb_mask = LSB_MASK_8;
      WW_16:   lane_lsb_mask = LSB_MASK_16;
      WW_32:   lane_lsb_mask = LSB_MASK_32;
      default: lane_lsb_mask = LSB_MASK_64;
    endcase
  endfunction

  // Number of iterations (= lane width in bits) for a width code
  function automatic logic [6:0] lane_width(input logic [1:0] ww);
    lane_width = 7'd8 << ww;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divmod_step.sv
//------------------------------------------------------------------------------
// divmod_step
// One restoring-division iteration for every lane in parallel. Each lane
// shifts {rem, dividend} left by one and subtracts the divisor when it fits.
// Purely combinational; all four lane widths are built and WW picks one.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divmod_step
  import alu_pkg::*;
(
  input  logic [0:63] i_rem,
  input  logic [0:63] i_div,
  input  logic [0:63] i_dsr,
  input  logic [1:0]  i_ww,
  output logic [0:63] o_rem,
  output logic [0:63] o_div,
  output logic [0:63] o_qbit
);

  logic [0:63] w_rem_c [4];
  logic [0:63] w_q_c   [4];

  for (genvar gw = 0; gw < 4; gw++) begin : g_width
    localparam int W = 8 << gw;
    localparam int N = 64 / W;

    logic [0:63] w_rem_w;
    logic [0:63] w_q_w;

    for (genvar gl = 0; gl < N; gl++) begin : g_lane
      localparam int B = gl * W;

      logic [W:0] w_sh;
      logic [W:0] w_diff;
      logic       w_ge;

      // W+1 bit window: the bit shifted out of the remainder still counts
      assign w_sh   = {i_rem[B +: W], i_div[B]};
      assign w_diff = w_sh - {1'b0, i_dsr[B +: W]};
      assign w_ge   = (w_sh >= {1'b0, i_dsr[B +: W]});

      // A zero divisor always "fits", so the lane ends with the dividend
      // as remainder and all-ones quotient without special casing.
      assign w_rem_w[B +: W] = w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
      assign w_q_w[B +: W]   = {{(W-1){1'b0}}, w_ge};
    end

    assign w_rem_c[gw] = w_rem_w;
    assign w_q_c[gw]   = w_q_w;
  end

  // Pick the lane-width variant and advance the dividend within each lane
  always_comb begin
    o_rem  = w_rem_c[3];
    o_qbit = w_q_c[3];
    case (i_ww)
      WW_8:  begin o_rem = w_rem_c[0]; o_qbit = w_q_c[0]; end
      WW_16: begin o_rem = w_rem_c[1]; o_qbit = w_q_c[1]; end
      WW_32: begin o_rem = w_rem_c[2]; o_qbit = w_q_c[2]; end
      default: begin o_rem = w_rem_c[3]; o_qbit = w_q_c[3]; end
    endcase
    o_div = (i_div << 1) & ~lane_lsb_mask(i_ww);
  end

endmodule

`default_nettype wire

// File: rtl/vec_divmod_unit.sv
//------------------------------------------------------------------------------
// vec_divmod_unit
// Multi-cycle VDIV/VMOD responder: lane-parallel unsigned restoring division
// with a start/busy/done handshake. Returns quotient or remainder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vec_divmod_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:DATA_W-1] rA_64bit_val,
  input  logic [0:DATA_W-1] rB_64bit_val,
  input  logic [0:5]        R_ins,
  input  logic [0:1]        WW,
  output logic              busy,
  output logic              done,
  output logic [0:DATA_W-1] div_out
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [0:63]        r_rem;
  logic [0:63]        r_div;
  logic [0:63]        r_dsr;
  logic [0:63]        r_quot;
  logic [5:0]         r_ins;
  logic [1:0]         r_ww;

  logic               w_accept;
  logic [0:63]        w_rem_nxt;
  logic [0:63]        w_div_nxt;
  logic [0:63]        w_qbit;
  logic [0:63]        w_quot_nxt;

  divmod_step u_step (
    .i_rem  (r_rem),
    .i_div  (r_div),
    .i_dsr  (r_dsr),
    .i_ww   (r_ww),
    .o_rem  (w_rem_nxt),
    .o_div  (w_div_nxt),
    .o_qbit (w_qbit)
  );

  // Only VDIV/VMOD starts seen in IDLE are taken
  assign w_accept   = (r_state == ST_IDLE) && start &&
                      ((R_ins == VDIV) || (R_ins == VMOD));
  // Quotient bits enter at each lane's LSB; the mask stops cross-lane spill
  assign w_quot_nxt = ((r_quot << 1) & ~lane_lsb_mask(r_ww)) | w_qbit;

  // Controller: capture on accept, iterate W times, then one DONE cycle.
  // The first RUN cycle raises busy, and the cycle after the last iteration
  // publishes the result, giving W+1 edges from accept to done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_dsr   <= '0;
      r_quot  <= '0;
      r_ins   <= '0;
      r_ww    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_div   <= rA_64bit_val;
            r_dsr   <= rB_64bit_val;
            r_ins   <= R_ins;
            r_ww    <= WW;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= CNT_W'(lane_width(WW));
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_cnt != '0) begin
            busy   <= 1'b1;
            r_rem  <= w_rem_nxt;
            r_div  <= w_div_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt - CNT_W'(1);
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            div_out <= (r_ins == VMOD) ? r_rem : r_quot;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
